// File: rtl/volt_text_buffer_if.sv
// Handshake and character-read bundle between the reading source, the
// text buffer and the text-drawing stage.
interface volt_text_buffer_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ch;
    logic [11:0] in_mv;
    logic [7:0]  text_xy;
    logic [6:0]  char_code;
    logic        busy;

    modport master (
        output in_valid, in_ch, in_mv, text_xy,
        input  in_ready, char_code, busy
    );

    modport slave (
        input  in_valid, in_ch, in_mv, text_xy,
        output in_ready, char_code, busy
    );
endinterface

// File: rtl/volt_text_buffer.sv
// 16x13 ASCII buffer of "CHnn: d.dddV " rows fed by a double-dabble converter.
// Optional OVERRANGE_FLAG_EN adds a '!' marker in col 12 when mv > OVR_LIMIT.
module volt_text_buffer #(
    parameter int unsigned CHANNELS  = 13,
    parameter int unsigned COLS      = 13,
`ifdef OVERRANGE_FLAG_EN
    parameter int unsigned OVR_LIMIT = 3300,
`endif
    parameter int unsigned ROWS      = 16
) (
    input  logic              pclk,
    input  logic              rst,
    volt_text_buffer_if.slave bus
);
    localparam int unsigned Depth   = ROWS * COLS;
    localparam logic [3:0]  ChanLim = 4'(CHANNELS);
    localparam logic [3:0]  LastCol = 4'(COLS - 1);
    localparam logic [6:0]  Space   = 7'h20;
    localparam logic [6:0]  Zero    = 7'h30;
`ifdef OVERRANGE_FLAG_EN
    localparam logic [3:0]  LastWr  = 4'd4;
`else
    localparam logic [3:0]  LastWr  = 4'd3;
`endif

    typedef enum logic [1:0] {StClear, StIdle, StConvert, StWrite} state_e;

    state_e      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  col_q, col_d;
    logic [3:0]  ch_q, ch_d;
    logic [11:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
`ifdef OVERRANGE_FLAG_EN
    logic [11:0] mv_q, mv_d;
`endif

    logic [6:0]  mem [Depth];
    logic [6:0]  char_q;
    logic        we;
    logic [7:0]  wa;
    logic [6:0]  wd;
    logic [3:0]  wcol;
    logic [7:0]  row_base;
    logic [15:0] bcd_adj;
    logic        in_ready;
    logic        busy;

    function automatic logic [6:0] template_char(input logic [3:0] row, input logic [3:0] col);
        logic [3:0] units;
        units = (row >= 4'd10) ? row - 4'd10 : row;
        if (row >= ChanLim) return Space;
        case (col)
            4'd0:                  return 7'h43;
            4'd1:                  return 7'h48;
            4'd2:                  return (row >= 4'd10) ? 7'h31 : Zero;
            4'd3:                  return Zero + {3'b000, units};
            4'd4:                  return 7'h3A;
            4'd6, 4'd8, 4'd9, 4'd10: return Zero;
            4'd7:                  return 7'h2E;
            4'd11:                 return 7'h56;
            default:               return Space;
        endcase
    endfunction

    function automatic logic [15:0] dd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign bcd_adj  = dd_adjust(bcd_q);
    assign row_base = 8'({4'b0000, ch_q} * 8'(COLS));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        row_d    = row_q;
        col_d    = col_q;
        ch_d     = ch_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
`ifdef OVERRANGE_FLAG_EN
        mv_d     = mv_q;
`endif
        we       = 1'b0;
        wa       = addr_q;
        wd       = Space;
        wcol     = 4'd12;
        in_ready = 1'b0;
        busy     = 1'b1;
        unique case (state_q)
            StClear: begin
                // addr_q leaves reset at 0xFF so the first CLEAR write lands the cycle after reset
                addr_d = addr_q + 8'd1;
                if (addr_q < 8'(Depth)) begin
                    we = 1'b1;
                    wd = template_char(row_q, col_q);
                    if (col_q == LastCol) begin
                        col_d = 4'd0;
                        row_d = row_q + 4'd1;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                    if (addr_q == 8'(Depth - 1)) state_d = StIdle;
                end
            end
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (bus.in_valid && bus.in_ch < ChanLim) begin
                    ch_d    = bus.in_ch;
                    bin_d   = bus.in_mv;
                    bcd_d   = '0;
                    cnt_d   = 4'd0;
`ifdef OVERRANGE_FLAG_EN
                    mv_d    = bus.in_mv;
`endif
                    state_d = StConvert;
                end
            end
            StConvert: begin
                bcd_d = {bcd_adj[14:0], bin_q[11]};
                bin_d = {bin_q[10:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd11) begin
                    cnt_d   = 4'd0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                we = 1'b1;
                case (cnt_q)
                    4'd0: begin wcol = 4'd6;  wd = Zero + {3'b000, bcd_q[15:12]}; end
                    4'd1: begin wcol = 4'd8;  wd = Zero + {3'b000, bcd_q[11:8]};  end
                    4'd2: begin wcol = 4'd9;  wd = Zero + {3'b000, bcd_q[7:4]};   end
                    4'd3: begin wcol = 4'd10; wd = Zero + {3'b000, bcd_q[3:0]};   end
`ifdef OVERRANGE_FLAG_EN
                    4'd4: begin wcol = 4'd12; wd = (mv_q > 12'(OVR_LIMIT)) ? 7'h21 : Space; end
`endif
                    default: begin wcol = 4'd12; wd = Space; end
                endcase
                wa    = row_base + {4'b0000, wcol};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LastWr) begin
                    cnt_d   = 4'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= StClear;
            addr_q  <= 8'hFF;
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            ch_q    <= 4'd0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= 4'd0;
`ifdef OVERRANGE_FLAG_EN
            mv_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ch_q    <= ch_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
`ifdef OVERRANGE_FLAG_EN
            mv_q    <= mv_d;
`endif
        end
    end

    always_ff @(posedge pclk) begin
        if (we) mem[wa] <= wd;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            char_q <= Space;
        end else if (bus.text_xy < 8'(Depth)) begin
            char_q <= mem[bus.text_xy];
        end else begin
            char_q <= Space;
        end
    end

    assign bus.char_code = char_q;
    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_volt_text_buffer.sv
// Randomised self-checking bench for volt_text_buffer against a character-level model.
module tb_volt_text_buffer;
    logic pclk;
    logic rst;
    int   vectors;
    int   miscompares;

`ifdef OVERRANGE_FLAG_EN
    localparam int ExpLow = 17;
`else
    localparam int ExpLow = 16;
`endif

    logic [6:0] model [208];

    volt_text_buffer_if bus ();

    volt_text_buffer dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic init_model();
        string s;
        for (int r = 0; r < 16; r++) begin
            s = $sformatf("CH%02d: 0.000V ", r);
            for (int c = 0; c < 13; c++) begin
                if (r < 13) model[r*13 + c] = 7'(s[c]);
                else        model[r*13 + c] = 7'h20;
            end
        end
    endtask

    task automatic update_model(input int ch, input int mv);
        if (ch >= 13) return;
        model[ch*13 + 6]  = 7'(48 + mv / 1000);
        model[ch*13 + 8]  = 7'(48 + (mv / 100) % 10);
        model[ch*13 + 9]  = 7'(48 + (mv / 10) % 10);
        model[ch*13 + 10] = 7'(48 + mv % 10);
`ifdef OVERRANGE_FLAG_EN
        model[ch*13 + 12] = (mv > 3300) ? 7'h21 : 7'h20;
`endif
    endtask

    function automatic logic [6:0] exp_char(input int a);
        if (a >= 208) return 7'h20;
        return model[a];
    endfunction

    task automatic read_char(input int a, output logic [6:0] c);
        bus.text_xy = 8'(a);
        @(posedge pclk); #1;
        c = bus.char_code;
    endtask

    // Returns the number of cycles in_ready stayed low after the handshake.
    task automatic send(input int ch, input int mv, output int low, output int busy_bad);
        int guard;
        guard = 0;
        low = 0;
        busy_bad = 0;
        while (bus.in_ready !== 1'b1 && guard < 500) begin
            @(posedge pclk); #1;
            guard++;
        end
        if (bus.in_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL send_wait: in_ready=%b required 1", bus.in_ready);
            low = -1;
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_ch    = 4'(ch);
        bus.in_mv    = 12'(mv);
        @(posedge pclk); #1;
        bus.in_valid = 1'b0;
        while (bus.in_ready !== 1'b1 && low < 100) begin
            if (bus.busy !== 1'b1) busy_bad++;
            low++;
            @(posedge pclk); #1;
        end
        if (bus.busy !== 1'b0) busy_bad++;
    endtask

    task automatic wait_ready_after_reset(input string name);
        int cyc;
        cyc = 0;
        while (cyc < 400) begin
            @(posedge pclk); #1;
            cyc++;
            if (bus.in_ready === 1'b1) break;
        end
        vectors++;
        if (cyc !== 209) begin
            miscompares++;
            $display("FAIL %s: in_ready rose after %0d cycles, required 209", name, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.char_code !== 7'h20) begin
            miscompares++;
            $display("FAIL reset_values: ready=%b busy=%b char=%h required 0 1 20",
                     bus.in_ready, bus.busy, bus.char_code);
        end
        rst = 1'b0;
        init_model();
        wait_ready_after_reset("reset_to_ready");
    endtask

    task automatic test_template();
        logic [6:0] c;
        for (int a = 0; a < 209; a++) begin
            read_char((a == 208) ? 250 : a, c);
            vectors++;
            if (c !== exp_char((a == 208) ? 250 : a)) begin
                miscompares++;
                $display("FAIL template[%0d]: got %h required %h", a, c,
                         exp_char((a == 208) ? 250 : a));
            end
        end
    endtask

    task automatic test_single();
        int low, bb;
        logic [6:0] c;
        send(3, 1234, low, bb);
        update_model(3, 1234);
        vectors++;
        if (low !== ExpLow || bb !== 0) begin
            miscompares++;
            $display("FAIL single_latency: low=%0d busy_bad=%0d required %0d 0", low, bb, ExpLow);
        end
        for (int a = 45; a <= 51; a++) begin
            read_char(a, c);
            vectors++;
            if (c !== exp_char(a)) begin
                miscompares++;
                $display("FAIL single_row3[%0d]: got %h required %h", a, c, exp_char(a));
            end
        end
    endtask

    task automatic test_back_to_back();
        int gap, guard;
        logic [6:0] c;
        bus.in_valid = 1'b1;
        bus.in_ch    = 4'd0;
        bus.in_mv    = 12'd4095;
        @(posedge pclk); #1;
        bus.in_mv = 12'd0;
        gap = 0;
        guard = 0;
        while (guard < 100) begin
            if (bus.in_ready === 1'b1) begin
                @(posedge pclk); #1;
                bus.in_valid = 1'b0;
                break;
            end
            gap++;
            guard++;
            @(posedge pclk); #1;
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (gap !== ExpLow) begin
            miscompares++;
            $display("FAIL b2b_holdoff: gap=%0d required %0d", gap, ExpLow);
        end
        update_model(0, 4095);
        for (int a = 6; a <= 10; a++) begin
            read_char(a, c);
            vectors++;
            if (c !== exp_char(a)) begin
                miscompares++;
                $display("FAIL b2b_first[%0d]: got %h required %h", a, c, exp_char(a));
            end
        end
        update_model(0, 0);
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(posedge pclk); #1;
            guard++;
        end
        for (int a = 6; a <= 11; a++) begin
            read_char(a, c);
            vectors++;
            if (c !== exp_char(a)) begin
                miscompares++;
                $display("FAIL b2b_second[%0d]: got %h required %h", a, c, exp_char(a));
            end
        end
    endtask

    task automatic test_drop();
        int bad;
        logic [6:0] c;
        bad = 0;
        bus.in_valid = 1'b1;
        bus.in_ch    = 4'd13;
        bus.in_mv    = 12'd999;
        @(posedge pclk); #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) bad++;
            @(posedge pclk); #1;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL drop_idle: %0d cycles not idle, required 0", bad);
        end
        for (int a = 0; a < 208; a++) begin
            read_char(a, c);
            vectors++;
            if (c !== exp_char(a)) begin
                miscompares++;
                $display("FAIL drop_ram[%0d]: got %h required %h", a, c, exp_char(a));
            end
        end
    endtask

`ifdef OVERRANGE_FLAG_EN
    task automatic test_overrange();
        int low, bb;
        logic [6:0] c;
        send(1, 3301, low, bb);
        update_model(1, 3301);
        read_char(25, c);
        vectors++;
        if (c !== 7'h21) begin
            miscompares++;
            $display("FAIL ovr_set: got %h required 21", c);
        end
        send(1, 3300, low, bb);
        update_model(1, 3300);
        read_char(25, c);
        vectors++;
        if (c !== 7'h20) begin
            miscompares++;
            $display("FAIL ovr_clear: got %h required 20", c);
        end
    endtask
`endif

    task automatic test_random();
        int ch, mv, low, bb;
        logic [6:0] c;
        for (int n = 0; n < 24; n++) begin
            ch = $urandom_range(0, 15);
            mv = (n < 4) ? ((n % 2 == 0) ? 4095 : 0) : $urandom_range(0, 4095);
            send(ch, mv, low, bb);
            update_model(ch, mv);
            vectors++;
            if (low !== ((ch < 13) ? ExpLow : 0) || bb !== 0) begin
                miscompares++;
                $display("FAIL rand_latency ch=%0d: low=%0d busy_bad=%0d required %0d 0",
                         ch, low, bb, (ch < 13) ? ExpLow : 0);
            end
            if (ch < 13) begin
                for (int col = 6; col <= 12; col++) begin
                    read_char(ch*13 + col, c);
                    vectors++;
                    if (c !== exp_char(ch*13 + col)) begin
                        miscompares++;
                        $display("FAIL rand_row ch=%0d mv=%0d col=%0d: got %h required %h",
                                 ch, mv, col, c, exp_char(ch*13 + col));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [6:0] c;
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(posedge pclk); #1;
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.in_ch    = 4'd5;
        bus.in_mv    = 12'd2500;
        @(posedge pclk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge pclk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b0;
        init_model();
        wait_ready_after_reset("abort_to_ready");
        for (int a = 0; a < 208; a++) begin
            read_char(a, c);
            vectors++;
            if (c !== exp_char(a)) begin
                miscompares++;
                $display("FAIL abort_ram[%0d]: got %h required %h", a, c, exp_char(a));
            end
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_ch    = 4'd0;
        bus.in_mv    = 12'd0;
        bus.text_xy  = 8'd0;
        test_reset();
        test_template();
        test_single();
        test_back_to_back();
        test_drop();
`ifdef OVERRANGE_FLAG_EN
        test_overrange();
`endif
        test_random();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
